// File: rtl/cu_mem_arbiter.sv
// rtl/cu_mem_arbiter.sv - two-requester arbiter for one shared SRAM/MMU port with timeout watchdog
//
// Purpose: grants the shared memory port to either instruction fetch (IF, read-only)
// or load/store (MEM, read/write), sequences IDLE -> ACCESS -> DONE, and returns read
// data or a timeout error to the granted requester with a one-cycle done pulse.
//
// Ports:
//   soc_clk, ARB_reset            clock (rising edge), asynchronous active-low reset
//   arb_stall                     blocks new grants in IDLE only
//   if_req/if_addr                IF request (level-held until if_done)
//   if_done/if_rdata              IF completion pulse and fetched word
//   mem_req/addr/we/be/wdata      MEM request (level-held until mem_done)
//   mem_done/mem_rdata            MEM completion pulse and read word
//   acc_err                       qualifies the done pulse: 1 = timed out
//   sram_req/addr/we/be/wdata     registered access to memory
//   sram_ready/sram_rdata         memory completion and read data
//   arb_owner                     current/last owner (0 = IF, 1 = MEM)
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants under contention;
// otherwise MEM has fixed priority over IF.
module cu_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BE_W        = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              soc_clk,
    input  logic              ARB_reset,
    input  logic              arb_stall,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_we,
    input  logic [BE_W-1:0]   mem_be,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              acc_err,
    output logic              sram_req,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we,
    output logic [BE_W-1:0]   sram_be,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_ready,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              arb_owner
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit WDOG_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              err_q, err_d;
    logic              grant_mem;

`ifdef ARB_ROUND_ROBIN_EN
    // Under contention hand the port to whoever did not own it last.
    assign grant_mem = mem_req && (!if_req || !owner_q);
`else
    assign grant_mem = mem_req;
`endif

    // Saturating increment: the counter never wraps even with the watchdog off.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_rdata_d  = '0;
        mem_rdata_d = '0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!arb_stall && (if_req || mem_req)) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                    if (grant_mem) begin
                        addr_d  = mem_addr;
                        we_d    = mem_we;
                        be_d    = mem_be;
                        wdata_d = mem_wdata;
                        owner_d = 1'b1;
                    end else begin
                        // Fetches are always full-word reads.
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        be_d    = '1;
                        wdata_d = '0;
                        owner_d = 1'b0;
                    end
                end
            end

            ST_ACCESS: begin
                // Ready is checked first so it beats a timeout on the same edge.
                if (sram_ready) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (owner_q) begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = we_q ? '0 : sram_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (WDOG_EN && (cnt_inc == CNT_TMO)) begin
                        state_d    = ST_DONE;
                        cnt_d      = '0;
                        err_d      = 1'b1;
                        if_done_d  = !owner_q;
                        mem_done_d = owner_q;
                    end
                end
            end

            ST_DONE: begin
                // Requests are deliberately ignored here so a held request
                // is re-evaluated only after the requester has seen done.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge soc_clk or negedge ARB_reset) begin
        if (!ARB_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            owner_q     <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            err_q       <= err_d;
        end
    end

    // Strobe decoded straight from the state register so reset drops it at once.
    assign sram_req   = (state_q == ST_ACCESS);
    assign sram_addr  = addr_q;
    assign sram_we    = we_q;
    assign sram_be    = be_q;
    assign sram_wdata = wdata_q;
    assign arb_owner  = owner_q;
    assign if_done    = if_done_q;
    assign mem_done   = mem_done_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign acc_err    = err_q;

endmodule

// File: tb/tb_cu_mem_arbiter.sv
// tb/tb_cu_mem_arbiter.sv - self-checking bench for cu_mem_arbiter
module tb_cu_mem_arbiter;

    localparam int T = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        soc_clk = 1'b0;
    logic        ARB_reset;
    logic        arb_stall;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        acc_err;
    logic        sram_req;
    logic [31:0] sram_addr;
    logic        sram_we;
    logic [3:0]  sram_be;
    logic [31:0] sram_wdata;
    logic        sram_ready;
    logic [31:0] sram_rdata;
    logic        arb_owner;

    cu_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .BE_W(4), .TIMEOUT_CYC(T)
    ) dut (
        .soc_clk(soc_clk), .ARB_reset(ARB_reset), .arb_stall(arb_stall),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .acc_err(acc_err), .sram_req(sram_req), .sram_addr(sram_addr),
        .sram_we(sram_we), .sram_be(sram_be), .sram_wdata(sram_wdata),
        .sram_ready(sram_ready), .sram_rdata(sram_rdata), .arb_owner(arb_owner)
    );

    always #5 soc_clk = ~soc_clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        mr;
        logic [31:0] ma;
        logic        mwe;
        logic [3:0]  mbe;
        logic [31:0] mwd;
        int          stall;
        int          wt;
        logic [31:0] rd;
        logic        e_own;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        int          e_len;
        logic        e_err;
        logic [31:0] e_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge soc_clk);
        #1;
    endtask

    // Drives one request set from IDLE and follows it through grant, access and done.
    task automatic run_vec(input vec_t v, input string tag);
        int k;
        if_req    = v.ifr;
        if_addr   = v.ifa;
        mem_req   = v.mr;
        mem_addr  = v.ma;
        mem_we    = v.mwe;
        mem_be    = v.mbe;
        mem_wdata = v.mwd;
        arb_stall = (v.stall > 0);
        for (int s = 0; s < v.stall; s++) begin
            tick();
            chk({tag, " stalled_no_req"}, {31'd0, sram_req}, 32'd0);
        end
        arb_stall = 1'b0;
        tick();
        chk({tag, " grant_latency"}, {31'd0, sram_req}, 32'd1);
        for (int i = 0; i < 5 && sram_req !== 1'b1; i++) tick();
        if (sram_req !== 1'b1) return;
        chk({tag, " owner"}, {31'd0, arb_owner}, {31'd0, v.e_own});
        chk({tag, " addr"}, sram_addr, v.e_addr);
        chk({tag, " we_be"}, {27'd0, sram_we, sram_be}, {27'd0, v.e_we, v.e_be});
        if (v.e_own) chk({tag, " wdata"}, sram_wdata, v.e_wd);
        k = 0;
        while (sram_req === 1'b1 && k < 20) begin
            sram_ready = (k >= v.wt);
            sram_rdata = (k >= v.wt) ? v.rd : ~v.rd;
            tick();
            k++;
            if (sram_req === 1'b1) begin
                chk({tag, " stable_addr"}, sram_addr, v.e_addr);
                chk({tag, " stable_we_be"}, {27'd0, sram_we, sram_be}, {27'd0, v.e_we, v.e_be});
            end
        end
        sram_ready = 1'b0;
        chk({tag, " access_len"}, 32'(k), 32'(v.e_len));
        chk({tag, " done_pair"}, {30'd0, if_done, mem_done}, {30'd0, !v.e_own, v.e_own});
        chk({tag, " acc_err"}, {31'd0, acc_err}, {31'd0, v.e_err});
        if (v.e_own) chk({tag, " mem_rdata"}, mem_rdata, v.e_rd);
        else         chk({tag, " if_rdata"}, if_rdata, v.e_rd);
        tick();
        chk({tag, " after_done"}, {29'd0, if_done, mem_done, acc_err}, 32'd0);
        chk({tag, " idle_no_req"}, {31'd0, sram_req}, 32'd0);
    endtask

    // Reference outcome of one access, from the arbitration and watchdog rules.
    function automatic vec_t predict(input vec_t v, input logic last_own);
        vec_t r = v;
        if (v.ifr && v.mr) r.e_own = RR ? !last_own : 1'b1;
        else               r.e_own = v.mr;
        r.e_addr = r.e_own ? v.ma : v.ifa;
        r.e_we   = r.e_own ? v.mwe : 1'b0;
        r.e_be   = r.e_own ? v.mbe : 4'hF;
        r.e_wd   = v.mwd;
        r.e_err  = (v.wt >= T);
        r.e_len  = (v.wt >= T) ? T : v.wt + 1;
        r.e_rd   = (r.e_err || r.e_we) ? 32'd0 : v.rd;
        return r;
    endfunction

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "time limit");
    end

    initial begin
        vec_t v;
        logic last_own;
        logic pi, pm;
        logic [31:0] pia, pma, pmwd;
        logic pmwe;
        logic [3:0] pmbe;

        // Contention: MEM,MEM,MEM,MEM fixed; MEM,IF,MEM,IF round robin.
        for (int i = 0; i < 4; i++) begin
            logic own;
            own = RR ? ((i % 2) == 0) : 1'b1;
            tbl[i] = '{1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 4'hF, 32'h0, 0, 0, 32'h1111_0000 + i,
                       own, own ? 32'h80 : 32'h40, 1'b0, 4'hF, 32'h0, 1, 1'b0, 32'h1111_0000 + i};
        end
        tbl[4] = '{1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 0, 32'hDEADBEEF,
                   1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 1, 1'b0, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 4'h3, 32'h1234ABCD, 0, 3, 32'h55,
                   1'b1, 32'h200, 1'b1, 4'h3, 32'h1234ABCD, 4, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 99, 32'h77,
                   1'b0, 32'h300, 1'b0, 4'hF, 32'h0, 4, 1'b1, 32'h0};
        tbl[7] = '{1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 3, 1, 32'hCAFEF00D,
                   1'b0, 32'h104, 1'b0, 4'hF, 32'h0, 2, 1'b0, 32'hCAFEF00D};
        tbl[8] = '{1'b0, 32'h0, 1'b1, 32'h208, 1'b0, 4'hC, 32'h0, 0, 2, 32'h0BADF00D,
                   1'b1, 32'h208, 1'b0, 4'hC, 32'h0, 3, 1'b0, 32'h0BADF00D};
        tbl[9] = '{1'b0, 32'h0, 1'b1, 32'h20C, 1'b0, 4'hF, 32'h0, 1, 5, 32'h99,
                   1'b1, 32'h20C, 1'b0, 4'hF, 32'h0, 4, 1'b1, 32'h0};

        ARB_reset = 1'b0; arb_stall = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_addr = '0; mem_we = 1'b0; mem_be = '0; mem_wdata = '0;
        sram_ready = 1'b0; sram_rdata = '0;
        tick(); tick();
        chk("reset ctrl", {26'd0, sram_req, if_done, mem_done, acc_err, arb_owner, sram_we}, 32'd0);
        chk("reset sram_addr", sram_addr, 32'd0);
        chk("reset sram_wdata", sram_wdata, 32'd0);
        chk("reset sram_be", {28'd0, sram_be}, 32'd0);
        chk("reset rdata", if_rdata | mem_rdata, 32'd0);
        ARB_reset = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        if_req = 1'b0; mem_req = 1'b0;

        // Reset in the middle of an access.
        tick();
        if_req = 1'b1; if_addr = 32'h500; sram_ready = 1'b0;
        tick();
        chk("rst_mid granted", {31'd0, sram_req}, 32'd1);
        tick();
        ARB_reset = 1'b0;
        #1;
        chk("rst_mid async drop", {31'd0, sram_req}, 32'd0);
        chk("rst_mid addr clear", sram_addr, 32'd0);
        tick();
        ARB_reset = 1'b1; if_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_mid quiet", {29'd0, sram_req, if_done, mem_done}, 32'd0);
        end
        run_vec(tbl[4], "post_reset");
        if_req = 1'b0;

        // Randomized traffic against the transaction-level model.
        last_own = 1'b0;
        pi = 1'b0; pm = 1'b0;
        pia = '0; pma = '0; pmwd = '0; pmwe = 1'b0; pmbe = '0;
        for (int r = 0; r < 150; r++) begin
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1'b1; pia = $urandom;
            end
            if (!pm && $urandom_range(0, 1) == 1) begin
                pm = 1'b1; pma = $urandom; pmwe = 1'($urandom); pmbe = 4'($urandom);
                pmwd = $urandom;
            end
            if (!pi && !pm) begin
                pi = 1'b1; pia = $urandom;
            end
            v = '{pi, pia, pm, pma, pmwe, pmbe, pmwd,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                  int'($urandom_range(0, 6)), $urandom,
                  1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 1'b0, 32'h0};
            v = predict(v, last_own);
            run_vec(v, $sformatf("rnd%0d", r));
            last_own = v.e_own;
            if (v.e_own) pm = 1'b0;
            else         pi = 1'b0;
        end
        if_req = 1'b0; mem_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
